// File: rtl/mdu_defs.sv
// Shared multiply/divide encodings and default latencies; the decoder and
// hazard unit import these same constants.
package mdu_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_WIDTH       = 32;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: maps a latched op and operands to the
// HI/LO values committed when the busy period ends.
module mdu_calc
    import mdu_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prodS;
    logic        [2*WIDTH-1:0] prodU;
    logic                      signedDiv;
    logic                      negA;
    logic                      negB;
    logic        [WIDTH-1:0]   magA;
    logic        [WIDTH-1:0]   magB;
    logic        [WIDTH-1:0]   divisor;
    logic        [WIDTH-1:0]   quotMag;
    logic        [WIDTH-1:0]   remMag;
    logic        [WIDTH-1:0]   divQ;
    logic        [WIDTH-1:0]   divR;

    assign prodS = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    assign prodU = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    // Signed division runs on magnitudes; quotient takes the xor of the signs,
    // remainder follows the dividend.
    assign signedDiv = (op_i == MD_DIV);
    assign negA      = signedDiv & a_i[WIDTH-1];
    assign negB      = signedDiv & b_i[WIDTH-1];
    assign magA      = negA ? -a_i : a_i;
    assign magB      = negB ? -b_i : b_i;
    assign divisor   = (b_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : magB;
    assign quotMag   = magA / divisor;
    assign remMag    = magA % divisor;
    assign divQ      = (negA ^ negB) ? -quotMag : quotMag;
    assign divR      = negA ? -remMag : remMag;

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        case (op_i)
            MD_MULT:  {hi_o, lo_o} = prodS;
            MD_MULTU: {hi_o, lo_o} = prodU;
            MD_DIV, MD_DIVU: begin
                if (b_i == '0) begin
                    hi_o = a_i;
                    lo_o = '1;
                end else if (signedDiv && a_i == MOST_NEG && b_i == '1) begin
                    hi_o = '0;
                    lo_o = a_i;
                end else begin
                    hi_o = divR;
                    lo_o = divQ;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage;
// Busy covers a fixed latency per operation class before results commit.
module mdu_unit
    import mdu_defs::*;
#(
    parameter int WIDTH       = MD_WIDTH,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [WIDTH-1:0] calcHi;
    logic [WIDTH-1:0] calcLo;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_o (calcHi),
        .lo_o (calcLo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Start is only honoured in IDLE; anything arriving during RUN is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (MDOp)
                        MD_MULT, MD_MULTU: begin
                            op_d    = MDOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            op_d    = MDOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = DIV_LOAD;
                            state_d = ST_RUN;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = calcHi;
                    lo_d    = calcLo;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
